// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
//
// Constants and small helpers shared by the clock chain counters (second,
// minute and hour counters).
//
//   SEC_MAX / MIN_MAX : highest legal seconds / minutes value (6-bit).
//   MODE_RUN/MODE_SET : encoding of the synchronized mode switch.
//   adj_e             : manual adjust request decoded from the press pulses.
//   wrap_inc/wrap_dec : modulo (max+1) step used by the adjust buttons and by
//                       the run-mode increment.
//   decode_adj        : turns the add/deduct press pulses into one request.
// -----------------------------------------------------------------------------
package clock_pkg;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;

  localparam logic       MODE_RUN = 1'b0;
  localparam logic       MODE_SET = 1'b1;

  typedef enum logic [1:0] {
    ADJ_NONE = 2'd0,
    ADJ_UP   = 2'd1,
    ADJ_DOWN = 2'd2
  } adj_e;

  // Step up, wrapping max -> 0.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  // Step down, wrapping 0 -> max.
  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
    return (v == 6'd0) ? max : v - 6'd1;
  endfunction

  // Both buttons pressed in the same cycle cancel out.
  function automatic adj_e decode_adj(input logic add_p, input logic deduct_p);
    adj_e a;
    a = ADJ_NONE;
    if (add_p && !deduct_p) a = ADJ_UP;
    else if (deduct_p && !add_p) a = ADJ_DOWN;
    return a;
  endfunction

endpackage

// File: rtl/btn_sync_fall.sv
// -----------------------------------------------------------------------------
// btn_sync_fall
//
// Multi-flop synchronizer for one raw asynchronous input, followed by a
// falling-edge detector. Intended for active-low pushbuttons: a press is a
// 1 -> 0 transition of the synchronized level and yields a single-cycle pulse.
// No debounce is done; every clean falling edge is one press.
//
// Latency from a raw edge to the fall pulse is SYNC_STAGES+1 clocks.
//
// Parameters:
//   SYNC_STAGES : synchronizer depth (>= 2).
//   RST_VAL     : value loaded into the chain and edge flop on reset. 1 for
//                 buttons (released), so reset never produces a press.
//
// Ports:
//   clk   in   system clock
//   reset in   asynchronous active-low reset
//   raw   in   unsynchronized input pin
//   sync  out  synchronized level
//   fall  out  one-cycle pulse on a 1 -> 0 transition of sync
// -----------------------------------------------------------------------------
module btn_sync_fall #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic sync,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_prev;
  logic                   r_fall;
  logic                   w_sync;

  assign w_sync = r_chain[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chain <= {SYNC_STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
      r_fall  <= 1'b0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], raw};
      r_prev  <= w_sync;
      // previous synchronized level high, current low
      r_fall  <= r_prev & ~w_sync;
    end
  end

  assign sync = w_sync;
  assign fall = r_fall;

endmodule

// File: rtl/second_counter.sv
// -----------------------------------------------------------------------------
// second_counter
//
// First stage of the clock chain. A prescaler divides the board clock down to
// a 1 Hz tick, and the tick advances a 0..59 seconds counter. The 59 -> 0
// rollover produces a one-cycle carry that feeds the minute counter.
//
// In set mode the prescaler is frozen at 0 and the add/deduct buttons step the
// seconds value up/down with wrap-around. Manual wraps never produce a carry.
//
// Parameters:
//   CLK_HZ      : input clock frequency; prescaler counts 0..CLK_HZ-1.
//   SYNC_STAGES : synchronizer depth for mode/add/deduct (>= 2).
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   mode     in   raw switch, 0 = run, 1 = set
//   add      in   raw pushbutton, active-low
//   deduct   in   raw pushbutton, active-low
//   second   out  seconds value 0..59
//   carry    out  one-cycle pulse on a run-mode 59 -> 0 rollover
//   tick_1hz out  one-cycle pulse on each prescaler wrap (run mode only)
// -----------------------------------------------------------------------------
module second_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       add,
  input  logic       deduct,
  output logic [5:0] second,
  output logic       carry,
  output logic       tick_1hz
);

  localparam int               PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

  logic             w_mode_s;
  logic             w_add_p;
  logic             w_deduct_p;
  logic             w_unused_mode_fall;
  logic             w_unused_add_sync;
  logic             w_unused_deduct_sync;
  adj_e             w_adj;

  logic [PRE_W-1:0] r_pre;
  logic [5:0]       r_second;
  logic             r_carry;
  logic             r_tick;

  // The mode chain resets to run rather than to the button idle level, so a
  // freshly reset clock starts counting on the first edge after release.
  btn_sync_fall #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (MODE_RUN)
  ) u_sync_mode (
    .clk   (clk),
    .reset (reset),
    .raw   (mode),
    .sync  (w_mode_s),
    .fall  (w_unused_mode_fall)
  );

  btn_sync_fall #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_sync_add (
    .clk   (clk),
    .reset (reset),
    .raw   (add),
    .sync  (w_unused_add_sync),
    .fall  (w_add_p)
  );

  btn_sync_fall #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_sync_deduct (
    .clk   (clk),
    .reset (reset),
    .raw   (deduct),
    .sync  (w_unused_deduct_sync),
    .fall  (w_deduct_p)
  );

  assign w_adj = decode_adj(w_add_p, w_deduct_p);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre    <= '0;
      r_second <= 6'd0;
      r_carry  <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_carry <= 1'b0;
      r_tick  <= 1'b0;
      if (w_mode_s == MODE_SET) begin
        // Set mode wins over a coincident wrap: the prescaler is simply
        // cleared, so no tick or carry can escape on the switch-over cycle.
        r_pre <= '0;
        case (w_adj)
          ADJ_UP:   r_second <= wrap_inc(r_second, SEC_MAX);
          ADJ_DOWN: r_second <= wrap_dec(r_second, SEC_MAX);
          default:  r_second <= r_second;
        endcase
      end else if (r_pre == PRE_MAX) begin
        r_pre   <= '0;
        r_tick  <= 1'b1;
        r_second <= wrap_inc(r_second, SEC_MAX);
        if (r_second >= SEC_MAX) r_carry <= 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  assign second   = r_second;
  assign carry    = r_carry;
  assign tick_1hz = r_tick;

endmodule

// File: doc/second_counter.md
Name: second_counter

Overview:
Upstream stage of the clock chain. It divides the board clock into a 1 Hz time base and counts seconds 0..59. It emits a one-cycle carry on every 59->0 rollover, and that carry drives the minute counter's `second` input. In set mode the block freezes the time base and lets the user adjust the seconds value with the active-low add/deduct buttons, using the same mode/button semantics as the minute counter.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency; the prescaler counts 0..CLK_HZ-1.
- SYNC_STAGES, 2, synchronizer depth for the mode/add/deduct inputs (minimum 2).

Ports:
- clk  in  1  system clock (CLK_HZ).
- reset  in  1  asynchronous, active-low reset. Asserts immediately; deasserts to run on the next clk edge.
- mode  in  1  0 = run, 1 = set. Raw switch input.
- add  in  1  raw pushbutton, active-low (pressed = 0).
- deduct  in  1  raw pushbutton, active-low (pressed = 0).
- second  out  6  current seconds value, 0..59, binary.
- carry  out  1  one-clk-wide pulse on a 59->0 run-mode rollover. Connects to the minute counter's `second` input.
- tick_1hz  out  1  one-clk-wide pulse each time the prescaler wraps, run mode only. For blink/display use.

Behaviour:
- Reset (reset=0) forces:
  - second=0, carry=0, tick_1hz=0.
  - prescaler=0.
  - synchronizer and edge-detect flops to 1 (button released), so no spurious press occurs after reset.
- Input conditioning:
  - mode, add and deduct each pass through SYNC_STAGES flops.
  - A press is a falling edge of the synchronized button: the previous value was 1 and the current value is 0. Each press yields exactly one cycle of add_p/deduct_p.
  - Latency from a pin edge to the press pulse is SYNC_STAGES+1 cycles.
  - No debounce filtering is done here; bounce produces multiple presses. The bench drives clean edges.
- Run mode (mode_s=0):
  - The prescaler increments every cycle. When it equals CLK_HZ-1 it wraps to 0 and tick_1hz=1 for that cycle.
  - On a tick:
    - If second==59: second<=0 and carry<=1.
    - Otherwise: second<=second+1.
  - carry and tick_1hz are registered outputs and high for exactly one cycle. Otherwise they are 0.
  - Button presses are ignored.
- Set mode (mode_s=1):
  - The prescaler is held at 0, and tick_1hz=0 and carry=0 always.
  - add_p:
    - If second==59: second<=0.
    - Otherwise: second+1.
    - No carry is generated; a manual wrap never advances minutes.
  - deduct_p:
    - If second==0: second<=59.
    - Otherwise: second-1.
  - If add_p and deduct_p occur in the same cycle, second is unchanged.
- Mode transitions:
  - set->run: the prescaler starts from 0, so the first tick comes a full CLK_HZ cycles after mode_s falls.
  - run->set: the prescaler clears on the first set cycle. A tick that coincides with the cycle mode_s rises is discarded, because set has priority.
- Arithmetic: second is 6-bit unsigned and never leaves 0..59. The prescaler width is $clog2(CLK_HZ).
- Reset asserted mid-operation clears everything at once, including an in-flight carry pulse.

Decomposition:
- Shared package clock_pkg:
  - SEC_MAX=59 and MIN_MAX=59, both 6-bit.
  - MODE_RUN=1'b0, MODE_SET=1'b1.
  - The minute and hour counters reuse these constants.
- Sub-module btn_sync_fall:
  - Parameter SYNC_STAGES.
  - Ports: clk, reset, raw in; sync out, fall pulse out.
  - Instantiated for add and deduct.
  - mode uses the same synchronizer chain, with the fall output unused.

Test Plan (CLK_HZ=10 for simulation):
- Reset: hold reset=0 for 3 cycles with mode=0, then release → second=0, carry=0, tick_1hz=0. The first tick_1hz arrives exactly 10 cycles after release and second becomes 1.
- Run rollover: preload to second=58 via set mode, then switch to run and wait 2 ticks → second goes 58→59→0, carry=1 for exactly one cycle coincident with the 59→0 update. The minute counter instance increments by 1.
- Set-mode adjust: mode=1, second=0, one deduct press → second=59, carry stays 0. Then 2 add presses → 59→0→1, carry stays 0, and no tick_1hz occurs over 50 cycles.
- Simultaneous press: mode=1, second=30, add and deduct falling on the same cycle → second stays 30.
- Press ignored in run: mode=0, second=5, add press mid-second → second unchanged until the next tick, then 6.
- Async reset mid-carry: assert reset=0 in the cycle carry=1 → carry and second go 0 without waiting for a clk edge. After release, counting restarts from 0.
